rs_multi_cdb: RTL and testbench

Parametrised reservation station that buffers dispatched ALU-class instructions until both operands are available, then issues them one per cycle to the ALU over a valid/ready handshake. It snoops N_CDB result buses per cycle and supports a whole-station flush on branch mispredict. It sits between dispatch/ROB allocation and the ALU, and frees an entry on issue rather than on writeback.

---
 rtl/rs_multi_cdb.sv | 200 ++++++++++++++++++++
 tb/tb_rs_multi_cdb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_multi_cdb.sv
// Reservation station for ALU-class instructions: holds dispatched ops until both
// operands arrive (via dispatch bypass or N_CDB-wide wakeup), then issues one per cycle.
module rs_multi_cdb #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned TP_W   = 3,
  parameter int unsigned N_CDB  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [OP_W-1:0]         disp_op,
  input  logic [TP_W-1:0]         disp_tp,
  input  logic                    disp_qj_wait,
  input  logic [ROB_W-1:0]        disp_qj,
  input  logic [DATA_W-1:0]       disp_vj,
  input  logic                    disp_qk_wait,
  input  logic [ROB_W-1:0]        disp_qk,
  input  logic [DATA_W-1:0]       disp_vk,
  input  logic [DATA_W-1:0]       disp_imm,
  input  logic [ROB_W-1:0]        disp_dest,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [OP_W-1:0]         iss_op,
  output logic [TP_W-1:0]         iss_tp,
  output logic [DATA_W-1:0]       iss_lhs,
  output logic [DATA_W-1:0]       iss_rhs,
  output logic [DATA_W-1:0]       iss_imm,
  output logic [ROB_W-1:0]        iss_dest,
  input  logic [N_CDB-1:0]        cdb_valid,
  input  logic [N_CDB*ROB_W-1:0]  cdb_tag,
  input  logic [N_CDB*DATA_W-1:0] cdb_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TP_W-1:0]   tp;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] imm;
    logic [ROB_W-1:0]  dest;
    logic              qj_wait;
    logic [ROB_W-1:0]  qj;
    logic              qk_wait;
    logic [ROB_W-1:0]  qk;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               hold_vld_q, hold_vld_d;
  logic [IDX_W-1:0]   hold_idx_q, hold_idx_d;

  logic [DEPTH-1:0]   rdy;
  logic [IDX_W-1:0]   low_idx, free_idx, sel_idx;
  logic               disp_fire, iss_fire;

  // Returns {hit, data}; scanning high-to-low lets the lowest matching channel win.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [ROB_W-1:0]        tag,
    input logic [N_CDB-1:0]        vld,
    input logic [N_CDB*ROB_W-1:0]  tags,
    input logic [N_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int c = int'(N_CDB) - 1; c >= 0; c--) begin
      if (vld[c] && (tags[c*ROB_W +: ROB_W] == tag)) r = {1'b1, data[c*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  // Ready vector, lowest ready / lowest free index, and the held-or-lowest selection.
  always_comb begin
    rdy      = '0;
    low_idx  = '0;
    free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = vld_q[i] && !ent_q[i].qj_wait && !ent_q[i].qk_wait;
      if (rdy[i])    low_idx  = IDX_W'(i);
      if (!vld_q[i]) free_idx = IDX_W'(i);
    end
    sel_idx = hold_vld_q ? hold_idx_q : low_idx;
  end

  assign disp_ready = (count_q != CNT_W'(DEPTH));
  assign iss_valid  = (|rdy) && !flush;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign iss_fire   = iss_valid && iss_ready;

  assign iss_op   = iss_valid ? ent_q[sel_idx].op   : '0;
  assign iss_tp   = iss_valid ? ent_q[sel_idx].tp   : '0;
  assign iss_lhs  = iss_valid ? ent_q[sel_idx].vj   : '0;
  assign iss_rhs  = iss_valid ? ent_q[sel_idx].vk   : '0;
  assign iss_imm  = iss_valid ? ent_q[sel_idx].imm  : '0;
  assign iss_dest = iss_valid ? ent_q[sel_idx].dest : '0;
  assign count    = count_q;

  // Next state: wakeup, issue free, dispatch write with bypass, flush clear.
  always_comb begin
    logic [DATA_W:0] lk;
    entry_t          ne;
    ent_d      = ent_q;
    vld_d      = vld_q;
    hold_vld_d = hold_vld_q;
    hold_idx_d = hold_idx_q;
    count_d    = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    lk         = '0;
    ne         = '0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_q[i].qj_wait) begin
        lk = cdb_lookup(ent_q[i].qj, cdb_valid, cdb_tag, cdb_data);
        if (lk[DATA_W]) begin
          ent_d[i].vj      = lk[DATA_W-1:0];
          ent_d[i].qj_wait = 1'b0;
        end
      end
      if (ent_q[i].qk_wait) begin
        lk = cdb_lookup(ent_q[i].qk, cdb_valid, cdb_tag, cdb_data);
        if (lk[DATA_W]) begin
          ent_d[i].vk      = lk[DATA_W-1:0];
          ent_d[i].qk_wait = 1'b0;
        end
      end
    end

    if (iss_fire) vld_d[sel_idx] = 1'b0;

    if (disp_fire) begin
      ne.op      = disp_op;
      ne.tp      = disp_tp;
      ne.imm     = disp_imm;
      ne.dest    = disp_dest;
      ne.qj      = disp_qj;
      ne.qk      = disp_qk;
      ne.vj      = disp_vj;
      ne.qj_wait = disp_qj_wait;
      ne.vk      = disp_vk;
      ne.qk_wait = disp_qk_wait;
      if (disp_qj_wait) begin
        lk = cdb_lookup(disp_qj, cdb_valid, cdb_tag, cdb_data);
        if (lk[DATA_W]) begin
          ne.vj      = lk[DATA_W-1:0];
          ne.qj_wait = 1'b0;
        end
      end
      if (disp_qk_wait) begin
        lk = cdb_lookup(disp_qk, cdb_valid, cdb_tag, cdb_data);
        if (lk[DATA_W]) begin
          ne.vk      = lk[DATA_W-1:0];
          ne.qk_wait = 1'b0;
        end
      end
      ent_d[free_idx] = ne;
      vld_d[free_idx] = 1'b1;
    end

    // A stalled presentation is pinned so a younger-ready lower index cannot preempt it.
    if (iss_fire) begin
      hold_vld_d = 1'b0;
    end else if (iss_valid) begin
      hold_vld_d = 1'b1;
      hold_idx_d = sel_idx;
    end

    if (flush) begin
      vld_d      = '0;
      count_d    = '0;
      hold_vld_d = 1'b0;
      hold_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q      <= '{default: '0};
      vld_q      <= '0;
      count_q    <= '0;
      hold_vld_q <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      ent_q      <= ent_d;
      vld_q      <= vld_d;
      count_q    <= count_d;
      hold_vld_q <= hold_vld_d;
      hold_idx_q <= hold_idx_d;
    end
  end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed bench for rs_multi_cdb: an occupancy-level model is compared on every cycle,
// and literal expectations pin the test-plan scenarios.
module tb_rs_multi_cdb;

  localparam int DEPTH = 8, DATA_W = 32, ROB_W = 4, OP_W = 6, TP_W = 3, N_CDB = 2;

  logic clk, rst, flush, disp_valid, disp_ready, iss_valid, iss_ready;
  logic [OP_W-1:0]   disp_op, iss_op;
  logic [TP_W-1:0]   disp_tp, iss_tp;
  logic              disp_qj_wait, disp_qk_wait;
  logic [ROB_W-1:0]  disp_qj, disp_qk, disp_dest, iss_dest;
  logic [DATA_W-1:0] disp_vj, disp_vk, disp_imm, iss_lhs, iss_rhs, iss_imm;
  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*ROB_W-1:0]  cdb_tag;
  logic [N_CDB*DATA_W-1:0] cdb_data;
  logic [$clog2(DEPTH):0]  count;

  rs_multi_cdb #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W),
                 .TP_W(TP_W), .N_CDB(N_CDB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_tp(disp_tp), .disp_qj_wait(disp_qj_wait), .disp_qj(disp_qj),
    .disp_vj(disp_vj), .disp_qk_wait(disp_qk_wait), .disp_qk(disp_qk), .disp_vk(disp_vk),
    .disp_imm(disp_imm), .disp_dest(disp_dest), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_tp(iss_tp), .iss_lhs(iss_lhs), .iss_rhs(iss_rhs), .iss_imm(iss_imm),
    .iss_dest(iss_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a table of slots, each either empty or holding an instruction.
  bit                mv  [DEPTH];
  logic [OP_W-1:0]   mop [DEPTH];
  logic [TP_W-1:0]   mtp [DEPTH];
  logic [DATA_W-1:0] mvj [DEPTH], mvk [DEPTH], mimm [DEPTH];
  logic [ROB_W-1:0]  mdest [DEPTH], mqj [DEPTH], mqk [DEPTH];
  bit                mjw [DEPTH], mkw [DEPTH];
  int                mhold;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mv[i] = 0;
    mhold = -1;
  endtask

  function automatic int m_occupancy();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mv[i]) n++;
    return n;
  endfunction

  function automatic int m_sel();
    if (mhold >= 0) return mhold;
    for (int i = 0; i < DEPTH; i++) if (mv[i] && !mjw[i] && !mkw[i]) return i;
    return -1;
  endfunction

  // First channel (lowest index) broadcasting the tag, as {hit, data}.
  function automatic logic [DATA_W:0] m_cdb(input logic [ROB_W-1:0] tag);
    for (int c = 0; c < N_CDB; c++)
      if (cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == tag) return {1'b1, cdb_data[c*DATA_W +: DATA_W]};
    return '0;
  endfunction

  task automatic compare();
    int s;
    bit ev;
    s  = m_sel();
    ev = (s >= 0) && !flush && rst;
    chk("iss_valid", 64'(iss_valid), 64'(ev));
    chk("count", 64'(count), 64'(m_occupancy()));
    chk("disp_ready", 64'(disp_ready), 64'(m_occupancy() != DEPTH));
    if (ev) begin
      chk("iss_op", 64'(iss_op), 64'(mop[s]));
      chk("iss_tp", 64'(iss_tp), 64'(mtp[s]));
      chk("iss_lhs", 64'(iss_lhs), 64'(mvj[s]));
      chk("iss_rhs", 64'(iss_rhs), 64'(mvk[s]));
      chk("iss_imm", 64'(iss_imm), 64'(mimm[s]));
      chk("iss_dest", 64'(iss_dest), 64'(mdest[s]));
    end else begin
      chk("iss_zero", {iss_lhs, iss_rhs}, 64'd0);
      chk("iss_zero2", 64'({iss_op, iss_tp, iss_imm, iss_dest}), 64'd0);
    end
  endtask

  task automatic model_edge();
    int s, fr;
    bit fire_i, fire_d;
    logic [DATA_W:0] h;
    if (!rst || flush) begin
      model_clear();
      return;
    end
    s      = m_sel();
    fire_i = (s >= 0) && iss_ready;
    fire_d = disp_valid && (m_occupancy() != DEPTH);
    fr = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!mv[i]) fr = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (mv[i] && mjw[i]) begin h = m_cdb(mqj[i]); if (h[DATA_W]) begin mvj[i] = h[DATA_W-1:0]; mjw[i] = 0; end end
      if (mv[i] && mkw[i]) begin h = m_cdb(mqk[i]); if (h[DATA_W]) begin mvk[i] = h[DATA_W-1:0]; mkw[i] = 0; end end
    end
    if (fire_i) mv[s] = 0;
    if (fire_d) begin
      mv[fr] = 1; mop[fr] = disp_op; mtp[fr] = disp_tp; mimm[fr] = disp_imm; mdest[fr] = disp_dest;
      mqj[fr] = disp_qj; mqk[fr] = disp_qk; mvj[fr] = disp_vj; mvk[fr] = disp_vk;
      mjw[fr] = disp_qj_wait; mkw[fr] = disp_qk_wait;
      if (disp_qj_wait) begin h = m_cdb(disp_qj); if (h[DATA_W]) begin mvj[fr] = h[DATA_W-1:0]; mjw[fr] = 0; end end
      if (disp_qk_wait) begin h = m_cdb(disp_qk); if (h[DATA_W]) begin mvk[fr] = h[DATA_W-1:0]; mkw[fr] = 0; end end
    end
    mhold = fire_i ? -1 : s;
  endtask

  // One cycle: compare mid-cycle, advance the model at the edge, return just after it.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic disp(input logic v, input logic [OP_W-1:0] op, input logic jw, input logic [ROB_W-1:0] qj,
                      input logic [DATA_W-1:0] vj, input logic kw, input logic [ROB_W-1:0] qk,
                      input logic [DATA_W-1:0] vk, input logic [ROB_W-1:0] dest);
    disp_valid = v; disp_op = op; disp_tp = TP_W'(op); disp_qj_wait = jw; disp_qj = qj; disp_vj = vj;
    disp_qk_wait = kw; disp_qk = qk; disp_vk = vk; disp_imm = DATA_W'(op) + 32'h100; disp_dest = dest;
  endtask

  task automatic cdb_clear();
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic cdb_set(input int ch, input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*ROB_W +: ROB_W] = tag;
    cdb_data[ch*DATA_W +: DATA_W] = data;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; iss_ready = 1'b1;
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cdb_clear();
    model_clear();
    tick(); tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    rst = 1'b1;
    tick();

    // Ready-at-dispatch: presented exactly one cycle later
    disp(1, 3, 0, 0, 5, 0, 0, 7, 2);
    #1 chk("t1_not_yet", 64'(iss_valid), 64'd0);
    tick();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_valid", 64'(iss_valid), 64'd1);
    chk("t1_lhs", 64'(iss_lhs), 64'd5);
    chk("t1_rhs", 64'(iss_rhs), 64'd7);
    chk("t1_dest", 64'(iss_dest), 64'd2);
    chk("t1_count1", 64'(count), 64'd1);
    tick();
    chk("t1_count0", 64'(count), 64'd0);

    // CDB wakeup on channel 1
    disp(1, 4, 1, 4, 0, 0, 0, 1, 5);
    tick();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("t2_waiting", 64'(iss_valid), 64'd0);
    cdb_set(1, 4, 32'hDEAD);
    tick();
    cdb_clear();
    chk("t2_valid", 64'(iss_valid), 64'd1);
    chk("t2_lhs", 64'(iss_lhs), 64'hDEAD);
    chk("t2_imm", 64'(iss_imm), 64'h104);
    tick();

    // Dispatch-cycle bypass on channel 0
    disp(1, 5, 1, 6, 0, 0, 0, 3, 7);
    cdb_set(0, 6, 32'd9);
    tick();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cdb_clear();
    chk("t3_valid", 64'(iss_valid), 64'd1);
    chk("t3_lhs", 64'(iss_lhs), 64'd9);
    tick();

    // Fill to DEPTH under backpressure, then drain in index order
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(1, OP_W'(i + 1), 0, 0, DATA_W'(i * 10), 0, 0, DATA_W'(i), ROB_W'(i));
      tick();
    end
    chk("t4_count8", 64'(count), 64'd8);
    chk("t4_full", 64'(disp_ready), 64'd0);
    disp(1, 9, 0, 0, 1, 0, 0, 1, 15);
    tick();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_reject", 64'(count), 64'd8);
    iss_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_order", 64'(iss_dest), 64'(i));
      tick();
    end
    chk("t4_drained", 64'(count), 64'd0);

    // Stalled entry 3 keeps the issue slot over a newly ready entry 1
    iss_ready = 1'b0;
    disp(1, 10, 1, 8, 0, 0, 0, 0, 12);  tick();
    disp(1, 11, 1, 9, 0, 0, 0, 0, 11);  tick();
    disp(1, 12, 1, 10, 0, 0, 0, 0, 13); tick();
    disp(1, 13, 0, 0, 33, 0, 0, 3, 3);  tick();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_present3", 64'(iss_dest), 64'd3);
    cdb_set(0, 9, 32'h99);
    tick();
    cdb_clear();
    tick();
    chk("t5_no_preempt", 64'(iss_dest), 64'd3);
    iss_ready = 1'b1;
    tick();
    chk("t5_next", 64'(iss_dest), 64'd11);
    chk("t5_next_lhs", 64'(iss_lhs), 64'h99);
    tick();
    chk("t5_idle", 64'(iss_valid), 64'd0);
    cdb_set(0, 8, 32'd1);
    cdb_set(1, 10, 32'd2);
    tick();
    cdb_clear();
    chk("t5_e0", 64'(iss_dest), 64'd12);
    tick();
    chk("t5_e2", 64'(iss_dest), 64'd13);
    chk("t5_e2_lhs", 64'(iss_lhs), 64'd2);
    tick();
    chk("t5_empty", 64'(count), 64'd0);

    // Flush with concurrent dispatch and issue requests
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(1, OP_W'(20 + i), 0, 0, 1, 0, 0, 2, ROB_W'(i));
      tick();
    end
    chk("t6_count5", 64'(count), 64'd5);
    disp(1, 30, 0, 0, 1, 0, 0, 2, 9);
    iss_ready = 1'b1;
    flush = 1'b1;
    #1 chk("t6_flush_iv", 64'(iss_valid), 64'd0);
    tick();
    flush = 1'b0;
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_count0", 64'(count), 64'd0);
    chk("t6_iv0", 64'(iss_valid), 64'd0);
    chk("t6_ready", 64'(disp_ready), 64'd1);
    tick();

    // Asynchronous reset mid-operation
    iss_ready = 1'b0;
    disp(1, 40, 0, 0, 4, 0, 0, 4, 1); tick();
    disp(1, 41, 0, 0, 4, 0, 0, 4, 2); tick();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    model_clear();
    chk("t7_count", 64'(count), 64'd0);
    chk("t7_iv", 64'(iss_valid), 64'd0);
    chk("t7_ready", 64'(disp_ready), 64'd1);
    tick();
    rst = 1'b1;
    iss_ready = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
